// File: rtl/serial_operand_driver_if.sv
// Handshake, serial-link and result signals of serial_operand_driver.
// The slave modport is the driver's view; master is the producer/adder/consumer side.
interface serial_operand_driver_if #(parameter int W = 8);
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         ser_vld;
  logic         ser_a;
  logic         ser_b;
  logic         ser_last;
  logic         ser_sum;
  logic         res_vld;
  logic [W-1:0] res;

  modport slave (
    input  in_vld, in_a, in_b, ser_sum,
    output in_rdy, ser_vld, ser_a, ser_b, ser_last, res_vld, res
  );

  modport master (
    output in_vld, in_a, in_b, ser_sum,
    input  in_rdy, ser_vld, ser_a, ser_b, ser_last, res_vld, res
  );
endinterface

// File: rtl/serial_operand_driver.sv
// Parallel-to-serial operand driver for the serial adder, LSB first, collecting the serial sum.
// Define SERIAL_OPERAND_DRIVER_BUBBLE_EN to insert one idle GAP cycle after every non-last bit.
module serial_operand_driver #(
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_operand_driver_if.slave  bus
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE, SHIFT, DONE
`ifdef SERIAL_OPERAND_DRIVER_BUBBLE_EN
    , GAP
`endif
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_inc;
  logic [W-1:0]   sh_a, sh_b;
  logic [W-1:0]   acc, acc_next, res_q;
  logic           in_rdy_q, ser_vld_q, ser_last_q, res_vld_q;
  logic           last_bit;

  assign idx_inc  = idx + 1'b1;
  assign last_bit = (idx == IW'(W - 1));

  // Sum bits enter at the MSB so after W shifts bit i sits at position i.
  generate
    if (W == 1) begin : g_acc1
      assign acc_next = bus.ser_sum;
    end else begin : g_accn
      assign acc_next = {bus.ser_sum, acc[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      sh_a       <= '0;
      sh_b       <= '0;
      acc        <= '0;
      res_q      <= '0;
      in_rdy_q   <= 1'b1;
      ser_vld_q  <= 1'b0;
      ser_last_q <= 1'b0;
      res_vld_q  <= 1'b0;
    end else begin
      res_vld_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_vld) begin
            sh_a       <= bus.in_a;
            sh_b       <= bus.in_b;
            idx        <= '0;
            state      <= SHIFT;
            in_rdy_q   <= 1'b0;
            ser_vld_q  <= 1'b1;
            ser_last_q <= (W == 1);
          end
        end
        SHIFT: begin
          acc        <= acc_next;
          sh_a       <= sh_a >> 1;
          sh_b       <= sh_b >> 1;
          ser_vld_q  <= 1'b0;
          ser_last_q <= 1'b0;
          if (last_bit) begin
            res_q     <= acc_next;
            res_vld_q <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx_inc;
`ifdef SERIAL_OPERAND_DRIVER_BUBBLE_EN
            state <= GAP;
`else
            state      <= SHIFT;
            ser_vld_q  <= 1'b1;
            ser_last_q <= (idx_inc == IW'(W - 1));
`endif
          end
        end
`ifdef SERIAL_OPERAND_DRIVER_BUBBLE_EN
        GAP: begin
          state      <= SHIFT;
          ser_vld_q  <= 1'b1;
          ser_last_q <= last_bit;
        end
`endif
        DONE: begin
          state    <= IDLE;
          in_rdy_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift registers keep their bit through GAP; gating by ser_vld zeroes the data lines there.
  assign bus.in_rdy   = in_rdy_q;
  assign bus.ser_vld  = ser_vld_q;
  assign bus.ser_a    = sh_a[0] & ser_vld_q;
  assign bus.ser_b    = sh_b[0] & ser_vld_q;
  assign bus.ser_last = ser_last_q;
  assign bus.res_vld  = res_vld_q;
  assign bus.res      = res_q;

endmodule

// File: tb/tb_serial_operand_driver.sv
// Scoreboard bench for serial_operand_driver with a behavioural serial adder on the link.
module tb_serial_operand_driver;
  localparam int W = 8;
`ifdef SERIAL_OPERAND_DRIVER_BUBBLE_EN
  localparam bit BUB = 1'b1;
`else
  localparam bit BUB = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           e0;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  logic carry;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   prev_e0 = 0;
  bit   chk_b2b = 1'b0;
  logic [W-1:0] exp_res = '0;
  item_t q[$];

  serial_operand_driver_if #(.W(W)) bus();
  serial_operand_driver #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial adder: sum is combinational, carry clears on last, synchronous reset from !rst.
  assign bus.ser_sum = bus.ser_a ^ bus.ser_b ^ carry;
  always @(posedge clk) begin
    if (!rst) carry <= 1'b0;
    else if (bus.ser_vld)
      carry <= bus.ser_last ? 1'b0 :
               ((bus.ser_a & bus.ser_b) | (bus.ser_a & carry) | (bus.ser_b & carry));
  end

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
  endfunction

  // Monitor: expected link and result activity derived from each accepted pair's edge E0.
  always @(negedge clk) begin
    int d, i;
    bit ev, el, ea, eb, er;
    logic [W-1:0] s;
    if (!rst) begin
      q.delete();
      exp_res = '0;
    end else begin
      ev = 0; el = 0; ea = 0; eb = 0; er = 0; i = -1;
      if (q.size() != 0) begin
        d = cyc - q[0].e0;
        if (BUB) begin
          if (d >= 0 && d <= 2*W-2 && (d % 2) == 0) i = d / 2;
          er = (d == 2*W-1);
        end else begin
          if (d >= 0 && d < W) i = d;
          er = (d == W);
        end
        if (i >= 0) begin
          ev = 1; ea = q[0].a[i]; eb = q[0].b[i]; el = (i == W-1);
        end
        if (er) begin
          s = q[0].a + q[0].b;
          exp_res = s;
        end
      end
      chk("ser_vld",  bus.ser_vld,  ev);
      chk("ser_a",    bus.ser_a,    ea);
      chk("ser_b",    bus.ser_b,    eb);
      chk("ser_last", bus.ser_last, el);
      chk("res_vld",  bus.res_vld,  er);
      chk("res",      bus.res,      exp_res);
      chk("in_rdy",   bus.in_rdy,   q.size() == 0);
      if (er) void'(q.pop_front());
      if (bus.in_vld && bus.in_rdy) begin
        if (chk_b2b) chk("b2b_spacing", cyc + 1 - prev_e0, BUB ? 2*W+1 : W+2);
        prev_e0 = cyc + 1;
        q.push_back('{bus.in_a, bus.in_b, cyc + 1});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    bit ok = 0;
    bus.in_vld = 1'b1; bus.in_a = a; bus.in_b = b;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (bus.in_rdy) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) chk("accept_timeout", 0, 1);
    if (!keep) bus.in_vld = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      if (q.size() == 0 && bus.in_rdy) ok = 1;
    end
    @(posedge clk); #1;
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b0;
    bus.in_vld = 1'b0; bus.in_a = '0; bus.in_b = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_rdy",  bus.in_rdy,  1);
    chk("rst_res_vld", bus.res_vld, 0);
    chk("rst_res",     bus.res,     0);
    chk("rst_ser_vld", bus.ser_vld, 0);
    chk("rst_ser_last", bus.ser_last, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    send(8'h05, 8'h03, 0); wait_done();
    send(8'hFF, 8'h01, 0); wait_done();
    send(8'h10, 8'h20, 0); wait_done();
    send(8'h7F, 8'h01, 0); wait_done();

    // Three pairs with in_vld held high throughout.
    send(8'h11, 8'h22, 1);
    chk_b2b = 1'b1;
    send(8'h33, 8'h44, 1);
    send(8'hF0, 8'h1F, 0);
    chk_b2b = 1'b0;
    wait_done();

    // A pulse on in_vld while shifting must not disturb the accepted pair.
    send(8'h3C, 8'h0F, 0);
    repeat (3) @(posedge clk);
    #1;
    bus.in_vld = 1'b1; bus.in_a = 8'hC3; bus.in_b = 8'hF0;
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of a word.
    send(8'hAA, 8'h55, 0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ser_vld", bus.ser_vld, 0);
    chk("arst_ser_a",   bus.ser_a,   0);
    chk("arst_in_rdy",  bus.in_rdy,  1);
    chk("arst_res",     bus.res,     0);
    chk("arst_res_vld", bus.res_vld, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    send(8'h01, 8'h01, 0); wait_done();

    for (int k = 0; k < 20; k++) begin
      logic [W-1:0] ra, rb;
      int gap;
      ra = W'($urandom);
      rb = W'($urandom);
      send(ra, rb, (k < 19) ? bit'($urandom % 2) : 1'b0);
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.in_vld = 1'b0;
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
